// File: rtl/m_bpred_pkg.sv
// ============================================================================
// Module      : m_bpred_pkg
// Description : Shared RV32 constants and PC helper for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package m_bpred_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    function automatic logic [XLEN-1:0] f_next_seq(input logic [XLEN-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_bpred_satcnt.sv
// ============================================================================
// Module      : m_satcnt
// Description : CBITS-wide saturating up/down counter with load and an
//               asynchronous reset value supplied on a port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_satcnt #(
    parameter int CBITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] i_rst_val,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [CBITS-1:0] i_load_val,
    output logic [CBITS-1:0] o_cnt
);

    localparam logic [CBITS-1:0] C_MAX = '1;

    logic [CBITS-1:0] r_cnt_q;
    logic [CBITS-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_load) begin
            w_cnt_d = i_load_val;
        end else if (i_inc && (r_cnt_q != C_MAX)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end else if (i_dec && (r_cnt_q != '0)) begin
            w_cnt_d = r_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q <= i_rst_val;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_cnt = r_cnt_q;

endmodule

`default_nettype wire

// File: rtl/m_bpred.sv
// ============================================================================
// Module      : m_bpred
// Description : Direct-mapped BTB with per-entry saturating direction
//               counters plus resolved-branch / mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_bpred
    import m_bpred_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CBITS   = 2,
    parameter int IDXW    = $clog2(ENTRIES),
    parameter int TAGW    = 30 - IDXW
) (
    input  logic            w_clk,
    input  logic            w_rst,
    input  logic [XLEN-1:0] w_pc,
    output logic            w_hit,
    output logic            w_ptkn,
    output logic [XLEN-1:0] w_ptgt,
    input  logic            w_upd,
    input  logic [XLEN-1:0] w_upc,
    input  logic            w_utkn,
    input  logic [XLEN-1:0] w_utgt,
    input  logic [XLEN-1:0] w_upred,
    input  logic            w_flush,
    output logic            w_mispred,
    output logic [XLEN-1:0] w_nbr,
    output logic [XLEN-1:0] w_nmis
);

    localparam logic [CBITS-1:0] C_CNT_RST = CBITS'((1 << (CBITS - 1)) - 1);
    localparam logic [CBITS-1:0] C_CNT_WT  = CBITS'(1 << (CBITS - 1));

    typedef struct packed {
        logic             valid;
        logic [TAGW-1:0]  tag;
        logic [XLEN-1:0]  target;
        logic [CBITS-1:0] cnt;
    } entry_t;

    function automatic logic [IDXW-1:0] f_idx(input logic [XLEN-1:0] pc);
        return pc[IDXW+1:2];
    endfunction

    function automatic logic [TAGW-1:0] f_tag(input logic [XLEN-1:0] pc);
        return pc[XLEN-1:IDXW+2];
    endfunction

    logic [ENTRIES-1:0]                r_valid_q, w_valid_d;
    logic [ENTRIES-1:0][TAGW-1:0]      r_tag_q,   w_tag_d;
    logic [ENTRIES-1:0][XLEN-1:0]      r_tgt_q,   w_tgt_d;
    logic [ENTRIES-1:0][CBITS-1:0]     w_cnt;
    logic [ENTRIES-1:0]                w_cinc, w_cdec, w_cload;
    logic [XLEN-1:0]                   r_nbr_q,  w_nbr_d;
    logic [XLEN-1:0]                   r_nmis_q, w_nmis_d;

    logic [IDXW-1:0] w_lidx, w_uidx;
    logic [TAGW-1:0] w_utag;
    logic            w_uhit;
    logic [XLEN-1:0] w_act;
    entry_t          w_lent;

    // Lookup sees only registered state, so a same-cycle update is not bypassed.
    always_comb begin
        w_lidx = f_idx(w_pc);
        w_lent = '{valid: r_valid_q[w_lidx], tag: r_tag_q[w_lidx],
                   target: r_tgt_q[w_lidx], cnt: w_cnt[w_lidx]};
        w_hit  = w_lent.valid && (w_lent.tag == f_tag(w_pc));
        w_ptkn = w_hit && w_lent.cnt[CBITS-1];
        w_ptgt = w_ptkn ? w_lent.target : f_next_seq(w_pc);
    end

    always_comb begin
        w_uidx    = f_idx(w_upc);
        w_utag    = f_tag(w_upc);
        w_uhit    = r_valid_q[w_uidx] && (r_tag_q[w_uidx] == w_utag);
        w_act     = w_utkn ? w_utgt : f_next_seq(w_upc);
        w_mispred = w_upd && (w_act != w_upred);
    end

    // Flush overrides any concurrent update for entry state.
    always_comb begin
        w_valid_d = r_valid_q;
        w_tag_d   = r_tag_q;
        w_tgt_d   = r_tgt_q;
        w_cinc    = '0;
        w_cdec    = '0;
        w_cload   = '0;
        if (w_flush) begin
            w_valid_d = '0;
        end else if (w_upd) begin
            if (w_uhit) begin
                if (w_utkn) begin
                    w_cinc[w_uidx]  = 1'b1;
                    w_tgt_d[w_uidx] = w_utgt;
                end else begin
                    w_cdec[w_uidx]  = 1'b1;
                end
            end else if (w_utkn) begin
                w_valid_d[w_uidx] = 1'b1;
                w_tag_d[w_uidx]   = w_utag;
                w_tgt_d[w_uidx]   = w_utgt;
                w_cload[w_uidx]   = 1'b1;
            end
        end
        w_nbr_d  = r_nbr_q  + {{(XLEN-1){1'b0}}, w_upd};
        w_nmis_d = r_nmis_q + {{(XLEN-1){1'b0}}, w_mispred};
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_valid_q <= '0;
            r_tag_q   <= '0;
            r_tgt_q   <= '0;
            r_nbr_q   <= '0;
            r_nmis_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_tag_q   <= w_tag_d;
            r_tgt_q   <= w_tgt_d;
            r_nbr_q   <= w_nbr_d;
            r_nmis_q  <= w_nmis_d;
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cnt
        m_satcnt #(
            .CBITS(CBITS)
        ) u_cnt (
            .clk        (w_clk),
            .rst        (w_rst),
            .i_rst_val  (C_CNT_RST),
            .i_inc      (w_cinc[gi]),
            .i_dec      (w_cdec[gi]),
            .i_load     (w_cload[gi]),
            .i_load_val (C_CNT_WT),
            .o_cnt      (w_cnt[gi])
        );
    end

    assign w_nbr  = r_nbr_q;
    assign w_nmis = r_nmis_q;

    // Byte-offset bits and non-MSB counter bits do not affect any output.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_pc[1:0], w_upc[1:0], w_lent};

endmodule

`default_nettype wire

// File: tb/tb_m_bpred.sv
// ============================================================================
// Module      : tb_m_bpred
// Description : Self-checking bench: directed vector table for the default
//               predictor, plus randomized traffic against a reference model
//               for both CBITS=2 and CBITS=3 instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_bpred;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, upc, utgt, upred;
    logic        upd, utkn, flush;

    logic        d0_hit, d0_ptkn, d0_mis, d1_hit, d1_ptkn, d1_mis;
    logic [31:0] d0_ptgt, d0_nbr, d0_nmis, d1_ptgt, d1_nbr, d1_nmis;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    m_bpred #(.ENTRIES(16), .CBITS(2)) dut (
        .w_clk(clk), .w_rst(rst), .w_pc(pc), .w_hit(d0_hit), .w_ptkn(d0_ptkn),
        .w_ptgt(d0_ptgt), .w_upd(upd), .w_upc(upc), .w_utkn(utkn), .w_utgt(utgt),
        .w_upred(upred), .w_flush(flush), .w_mispred(d0_mis), .w_nbr(d0_nbr),
        .w_nmis(d0_nmis)
    );

    m_bpred #(.ENTRIES(16), .CBITS(3)) dut3 (
        .w_clk(clk), .w_rst(rst), .w_pc(pc), .w_hit(d1_hit), .w_ptkn(d1_ptkn),
        .w_ptgt(d1_ptgt), .w_upd(upd), .w_upc(upc), .w_utkn(utkn), .w_utgt(utgt),
        .w_upred(upred), .w_flush(flush), .w_mispred(d1_mis), .w_nbr(d1_nbr),
        .w_nmis(d1_nmis)
    );

    // Reference model: index k=0 is CBITS=2, k=1 is CBITS=3; 16 entries each.
    logic        m_v   [2][16];
    logic [31:0] m_tag [2][16];
    logic [31:0] m_tg  [2][16];
    int          m_cnt [2][16];
    logic [31:0] m_nbr, m_nmis;

    function automatic int cb(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int ix(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic logic m_hit(input int k, input logic [31:0] a);
        return m_v[k][ix(a)] && (m_tag[k][ix(a)] == (a >> 6));
    endfunction

    function automatic logic m_tkn(input int k, input logic [31:0] a);
        return m_hit(k, a) && (m_cnt[k][ix(a)] >= (1 << (cb(k) - 1)));
    endfunction

    function automatic logic [31:0] m_ptgt(input int k, input logic [31:0] a);
        return m_tkn(k, a) ? m_tg[k][ix(a)] : a + 32'd4;
    endfunction

    function automatic logic m_mis();
        logic [31:0] act;
        act = utkn ? utgt : upc + 32'd4;
        return upd && (act != upred);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                m_v[k][i]   = 1'b0;
                m_tag[k][i] = '0;
                m_tg[k][i]  = '0;
                m_cnt[k][i] = (1 << (cb(k) - 1)) - 1;
            end
        end
        m_nbr  = '0;
        m_nmis = '0;
    endtask

    task automatic m_update();
        int u;
        u = ix(upc);
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                for (int i = 0; i < 16; i++) m_v[k][i] = 1'b0;
            end else if (upd) begin
                if (m_hit(k, upc)) begin
                    if (utkn) begin
                        if (m_cnt[k][u] < (1 << cb(k)) - 1) m_cnt[k][u]++;
                        m_tg[k][u] = utgt;
                    end else if (m_cnt[k][u] > 0) begin
                        m_cnt[k][u]--;
                    end
                end else if (utkn) begin
                    m_v[k][u]   = 1'b1;
                    m_tag[k][u] = upc >> 6;
                    m_tg[k][u]  = utgt;
                    m_cnt[k][u] = 1 << (cb(k) - 1);
                end
            end
        end
        if (upd) begin
            if (m_mis()) m_nmis = m_nmis + 32'd1;
            m_nbr = m_nbr + 32'd1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic mcheck();
        chk("hit",    32'(d0_hit),  32'(m_hit(0, pc)));
        chk("ptkn",   32'(d0_ptkn), 32'(m_tkn(0, pc)));
        chk("ptgt",   d0_ptgt,      m_ptgt(0, pc));
        chk("hit3",   32'(d1_hit),  32'(m_hit(1, pc)));
        chk("ptkn3",  32'(d1_ptkn), 32'(m_tkn(1, pc)));
        chk("ptgt3",  d1_ptgt,      m_ptgt(1, pc));
        chk("mispred",  32'(d0_mis), 32'(m_mis()));
        chk("mispred3", 32'(d1_mis), 32'(m_mis()));
        chk("nbr",   d0_nbr,  m_nbr);
        chk("nmis",  d0_nmis, m_nmis);
        chk("nbr3",  d1_nbr,  m_nbr);
        chk("nmis3", d1_nmis, m_nmis);
    endtask

    task automatic drive(input logic [31:0] a, input logic u, input logic [31:0] ua,
                         input logic t, input logic [31:0] tg, input logic [31:0] pr,
                         input logic f);
        pc = a; upd = u; upc = ua; utkn = t; utgt = tg; upred = pr; flush = f;
    endtask

    task automatic cyc(input logic [31:0] a, input logic u, input logic [31:0] ua,
                       input logic t, input logic [31:0] tg, input logic [31:0] pr,
                       input logic f);
        drive(a, u, ua, t, tg, pr, f);
        @(negedge clk);
        mcheck();
        @(posedge clk);
        m_update();
        #1;
    endtask

    // Reset asserted between edges while an update is pending.
    task automatic mid_reset(input logic [31:0] a);
        drive(a, 1'b1, a, 1'b1, 32'h100, 32'h0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("rst_hit",   32'(d0_hit),  32'd0);
        chk("rst_hit3",  32'(d1_hit),  32'd0);
        chk("rst_ptkn",  32'(d0_ptkn), 32'd0);
        chk("rst_ptgt",  d0_ptgt,      a + 32'd4);
        chk("rst_nbr",   d0_nbr,       32'd0);
        chk("rst_nmis",  d0_nmis,      32'd0);
        chk("rst_nbr3",  d1_nbr,       32'd0);
        chk("rst_mispred", 32'(d0_mis), 32'(m_mis()));
        m_reset();
        @(negedge clk);
        upd = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        upd;
        logic [31:0] upc;
        logic        utkn;
        logic [31:0] utgt;
        logic [31:0] upred;
        logic        flush;
        logic        e_hit;
        logic        e_tkn;
        logic [31:0] e_tgt;
        logic        e_mis;
        logic [31:0] e_nbr;
        logic [31:0] e_nmis;
    } vec_t;

    vec_t vt[17];

    initial begin
        // pc  upd upc  tkn utgt upred flush | hit tkn tgt mis nbr nmis
        vt[0]  = '{32'd12,  1'b0, 32'd0,   1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 1'b0, 32'd16,  1'b0, 32'd0, 32'd0};
        vt[1]  = '{32'd12,  1'b1, 32'd12,  1'b1, 32'd8,  32'd16,  1'b0, 1'b0, 1'b0, 32'd16,  1'b1, 32'd0, 32'd0};
        vt[2]  = '{32'd12,  1'b1, 32'd12,  1'b1, 32'd8,  32'd8,   1'b0, 1'b1, 1'b1, 32'd8,   1'b0, 32'd1, 32'd1};
        vt[3]  = '{32'd12,  1'b1, 32'd12,  1'b1, 32'd8,  32'd8,   1'b0, 1'b1, 1'b1, 32'd8,   1'b0, 32'd2, 32'd1};
        vt[4]  = '{32'd12,  1'b1, 32'd12,  1'b1, 32'd8,  32'd8,   1'b0, 1'b1, 1'b1, 32'd8,   1'b0, 32'd3, 32'd1};
        vt[5]  = '{32'd12,  1'b1, 32'd12,  1'b0, 32'd8,  32'd8,   1'b0, 1'b1, 1'b1, 32'd8,   1'b1, 32'd4, 32'd1};
        vt[6]  = '{32'd12,  1'b1, 32'd12,  1'b0, 32'd8,  32'd8,   1'b0, 1'b1, 1'b1, 32'd8,   1'b1, 32'd5, 32'd2};
        vt[7]  = '{32'd12,  1'b0, 32'd0,   1'b0, 32'd0,  32'd0,   1'b0, 1'b1, 1'b0, 32'd16,  1'b0, 32'd6, 32'd3};
        vt[8]  = '{32'd76,  1'b0, 32'd0,   1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 1'b0, 32'd80,  1'b0, 32'd6, 32'd3};
        vt[9]  = '{32'd76,  1'b1, 32'd76,  1'b1, 32'd40, 32'd80,  1'b0, 1'b0, 1'b0, 32'd80,  1'b1, 32'd6, 32'd3};
        vt[10] = '{32'd76,  1'b0, 32'd0,   1'b0, 32'd0,  32'd0,   1'b0, 1'b1, 1'b1, 32'd40,  1'b0, 32'd7, 32'd4};
        vt[11] = '{32'd12,  1'b0, 32'd0,   1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 1'b0, 32'd16,  1'b0, 32'd7, 32'd4};
        vt[12] = '{32'd200, 1'b1, 32'd200, 1'b0, 32'd0,  32'd204, 1'b0, 1'b0, 1'b0, 32'd204, 1'b0, 32'd7, 32'd4};
        vt[13] = '{32'd200, 1'b0, 32'd0,   1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 1'b0, 32'd204, 1'b0, 32'd8, 32'd4};
        vt[14] = '{32'd76,  1'b1, 32'd12,  1'b1, 32'd8,  32'd16,  1'b1, 1'b1, 1'b1, 32'd40,  1'b1, 32'd8, 32'd4};
        vt[15] = '{32'd76,  1'b0, 32'd0,   1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 1'b0, 32'd80,  1'b0, 32'd9, 32'd5};
        vt[16] = '{32'd12,  1'b0, 32'd0,   1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 1'b0, 32'd16,  1'b0, 32'd9, 32'd5};

        rst = 1'b1;
        drive(32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].pc, vt[i].upd, vt[i].upc, vt[i].utkn, vt[i].utgt, vt[i].upred, vt[i].flush);
            @(negedge clk);
            mcheck();
            chk($sformatf("v%0d_hit", i),  32'(d0_hit),  32'(vt[i].e_hit));
            chk($sformatf("v%0d_ptkn", i), 32'(d0_ptkn), 32'(vt[i].e_tkn));
            chk($sformatf("v%0d_ptgt", i), d0_ptgt,      vt[i].e_tgt);
            chk($sformatf("v%0d_mis", i),  32'(d0_mis),  32'(vt[i].e_mis));
            chk($sformatf("v%0d_nbr", i),  d0_nbr,       vt[i].e_nbr);
            chk($sformatf("v%0d_nmis", i), d0_nmis,      vt[i].e_nmis);
            @(posedge clk);
            m_update();
            #1;
        end

        // Async reset mid-update, then CBITS=3 sweep from the fresh state.
        mid_reset(32'd12);
        cyc(32'd12, 1'b1, 32'd12, 1'b1, 32'd8, 32'd16, 1'b0);
        drive(32'd12, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1 chk("c3_alloc_ptkn", 32'(d1_ptkn), 32'd1);
        cyc(32'd12, 1'b1, 32'd12, 1'b0, 32'd8, 32'd8, 1'b0);
        drive(32'd12, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1 chk("c3_weak_nt", 32'(d1_ptkn), 32'd0);
        for (int i = 0; i < 6; i++) cyc(32'd12, 1'b1, 32'd12, 1'b1, 32'd8, 32'd8, 1'b0);
        for (int i = 0; i < 9; i++) cyc(32'd12, 1'b1, 32'd12, 1'b0, 32'd8, 32'd16, 1'b0);
        cyc(32'd12, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Randomized traffic over a small aliasing address pool.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, ua, tg, pr;
            logic u, t, f;
            if (n % 150 == 149) begin
                mid_reset({$urandom_range(0, 3), 6'd0} | ($urandom_range(0, 15) << 2));
            end else begin
                a  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                ua = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                tg = $urandom & 32'hFFFF_FFFC;
                u  = ($urandom_range(0, 3) != 0);
                t  = ($urandom_range(0, 2) != 0);
                f  = ($urandom_range(0, 39) == 0);
                pr = ($urandom_range(0, 3) != 0) ? m_ptgt(0, ua) : ($urandom & 32'hFFFF_FFFC);
                cyc(a, u, ua, t, tg, pr, f);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/m_bpred.md
Name: m_bpred

Overview:
- Parametrised branch predictor for the pipelined RV32I core.
- It combines a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- The IF stage looks up the current PC combinationally. The EX stage writes back each resolved branch outcome.
- The block also counts resolved branches and mispredictions, so loop behaviour can be checked in simulation.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of 2, at least 2.
- CBITS, 2, direction counter width; at least 1.
- IDXW, $clog2(ENTRIES), index width; derived, never overridden.
- TAGW, 30-IDXW, tag width; derived.

Ports:
- w_clk  in  1  clock, rising edge.
- w_rst  in  1  reset, asynchronous, active-high.
- w_pc  in  32  IF-stage fetch PC (lookup).
- w_hit  out  1  lookup hit: the entry is valid and its tag matches.
- w_ptkn  out  1  predicted taken.
- w_ptgt  out  32  predicted next PC.
- w_upd  in  1  EX-stage update valid: a resolved branch this cycle.
- w_upc  in  32  PC of the resolved branch.
- w_utkn  in  1  actual outcome of the resolved branch.
- w_utgt  in  32  actual target of the resolved branch.
- w_upred  in  32  next PC that was predicted for this branch, carried down the pipeline.
- w_flush  in  1  invalidate all entries.
- w_mispred  out  1  combinational: w_upd & (actual next PC != w_upred).
- w_nbr  out  32  count of resolved branches.
- w_nmis  out  32  count of mispredictions.

Behaviour:
- Address split: idx = pc[IDXW+1:2]; tag = pc[31:IDXW+2]; pc[1:0] is ignored.
- Entry state: valid bit, TAGW-bit tag, 32-bit target, CBITS-bit counter.
- Lookup is purely combinational from the registered state, with zero latency:
  - w_hit = valid[idx] & (tag[idx] == tag(w_pc)).
  - w_ptkn = w_hit & counter MSB.
  - w_ptgt = w_ptkn ? target[idx] : w_pc+4.
- Actual next PC = w_utkn ? w_utgt : w_upc+4.
- Update on the rising edge when w_upd=1, at entry u = idx(w_upc):
  - Tag hit: counter increments if w_utkn, else decrements. It saturates at 2^CBITS-1 and at 0, never wrapping. If w_utkn, the target is overwritten with w_utgt.
  - Tag miss and w_utkn=1: the entry is replaced. valid=1, tag=tag(w_upc), target=w_utgt, counter=2^(CBITS-1) (weakly taken).
  - Tag miss and w_utkn=0: no state change. Not-taken branches never allocate.
- Counters:
  - w_nbr increments on every w_upd.
  - w_nmis increments when w_upd & w_mispred.
  - Both wrap modulo 2^32.
- Lookup and update in the same cycle to the same index: the lookup returns the pre-update state. There is no bypass; the new state is visible the next cycle.
- w_flush (synchronous): on the edge, all valid bits clear. Targets, tags and counters are retained.
  - Flush together with w_upd: flush wins for entry state, so nothing is allocated or modified.
  - w_nbr and w_nmis still count that update.
- Reset (asynchronous, active-high), effective immediately, including in the middle of an update:
  - All valid bits = 0; all counters = 2^(CBITS-1)-1 (weakly not-taken); targets and tags = 0.
  - w_nbr = w_nmis = 0.
  - Outputs during reset: w_hit=0, w_ptkn=0, w_ptgt=w_pc+4, w_mispred follows its inputs.
- Unknown-free: w_hit, w_ptkn and w_ptgt are never X after reset for any defined w_pc.

Decomposition:
- Shared package holds the RV32 constants: XLEN=32, PC increment 4, and the BTB entry struct (valid, tag, target, counter). The struct is parametrised by TAGW and CBITS, or expressed as localparams in an include.
- One natural sub-module: m_satcnt, a CBITS-wide saturating up/down counter with async reset value input. It is instantiated per entry through a generate loop.
- Index/tag extraction stays in m_bpred as functions.

Test Plan:
- Reset, then lookup w_pc=12 -> w_hit=0, w_ptkn=0, w_ptgt=16; w_nbr=w_nmis=0.
- Loop branch allocation:
  - Update w_upc=12, w_utkn=1, w_utgt=8, w_upred=16 -> w_mispred=1.
  - Next cycle lookup 12 -> w_hit=1, w_ptkn=1, w_ptgt=8; w_nbr=1, w_nmis=1.
- Saturation and direction change:
  - 3 more taken updates at pc 12 (w_upred=8) -> counter=3, w_nmis unchanged.
  - Then 2 not-taken updates -> counter=1, lookup gives w_ptkn=0, w_ptgt=16.
  - The first not-taken update, with w_upred=8, counts as a mispredict.
- Aliasing (ENTRIES=16):
  - After allocating pc 12, lookup pc 76 -> w_hit=0.
  - Taken update at pc 76 with target 40 -> lookup 76 hits with w_ptgt=40, and lookup 12 misses.
  - Not-taken update at an unallocated pc 200 -> lookup 200 still misses.
- Same-cycle hazard and flush:
  - Lookup 12 in the same cycle as the first taken update to 12 -> w_hit=0 that cycle, 1 the next.
  - w_flush together with an update -> all lookups miss afterwards, and w_nbr still increments.
- Async reset:
  - Assert w_rst mid-cycle between edges while w_upd=1 -> w_hit drops and counters read 0 before the next edge.
  - After release, a counter sweep with CBITS=3 starts from 3 (weakly not-taken).
